// File: rtl/wb_stream_writer_sched.sv
// Descriptor-driven scheduler for a Wishbone-configured stream writer.
// Each accepted descriptor is programmed into the writer as four single
// register writes (address, size, burst length, enable). The block then waits
// for the writer's completion interrupt, clears it with a fifth write, and
// emits a done pulse. Bus errors park the block in a sticky ERROR state until
// software clears it.
//
// Handshake: a descriptor is transferred on a rising clk edge where
// desc_valid_i && desc_ready_o; desc_adr_i/desc_size_i are captured on that
// edge. desc_valid_i may be asserted independently of desc_ready_o, and
// desc_ready_o never depends combinationally on desc_valid_i.
module wb_stream_writer_sched #(
  parameter int               WB_AW     = 32,
  parameter int               WB_DW     = 32,
  parameter logic [WB_AW-1:0] CFG_BASE  = '0,
  parameter int               BURST_LEN = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WB_AW-1:0]   desc_adr_i,
  input  logic [WB_AW-1:0]   desc_size_i,
  input  logic               desc_valid_i,
  output logic               desc_ready_o,
  output logic [WB_AW-1:0]   wbm_adr_o,
  output logic [WB_DW-1:0]   wbm_dat_o,
  output logic [WB_DW/8-1:0] wbm_sel_o,
  output logic               wbm_we_o,
  output logic               wbm_cyc_o,
  output logic               wbm_stb_o,
  output logic [2:0]         wbm_cti_o,
  output logic [1:0]         wbm_bte_o,
  input  logic [WB_DW-1:0]   wbm_dat_i,
  input  logic               wbm_ack_i,
  input  logic               wbm_err_i,
  input  logic               wbm_rty_i,
  input  logic               writer_irq_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [15:0]        done_cnt_o,
  output logic               err_o,
  input  logic               err_clr_i
);

  typedef enum logic [3:0] {
    IDLE, WR_ADR, WR_SIZE, WR_BURST, WR_EN, WAIT_IRQ, CLR_IRQ, DONE, ERROR
  } state_t;

  localparam logic [WB_AW-1:0] REG_CTRL  = CFG_BASE;
  localparam logic [WB_AW-1:0] REG_ADR   = CFG_BASE + WB_AW'(4);
  localparam logic [WB_AW-1:0] REG_SIZE  = CFG_BASE + WB_AW'(8);
  localparam logic [WB_AW-1:0] REG_BURST = CFG_BASE + WB_AW'(12);

  state_t             state_q, state_d;
  logic               accept;
  logic               bus_gap;
  logic               stb_d;
  logic [WB_AW-1:0]   adr_d;
  logic [WB_DW-1:0]   dat_d;
  logic [WB_AW-1:0]   desc_adr_q, desc_size_q;
  logic [WB_AW-1:0]   adr_lat, size_lat;
  logic [15:0]        done_cnt_q;
  logic               rd_data_unused;

  // Read data has no meaning for a write-only master.
  assign rd_data_unused = ^wbm_dat_i;

  // Only single classic-cycle writes are issued.
  assign wbm_cti_o = 3'b000;
  assign wbm_bte_o = 2'b00;

  assign desc_ready_o = (state_q == IDLE) && !err_o;
  assign accept       = desc_valid_i && desc_ready_o;
  assign done_cnt_o   = done_cnt_q;

  // The descriptor is used on the very cycle it is accepted, before the
  // latch has caught it, so look through to the inputs on that cycle.
  assign adr_lat  = accept ? desc_adr_i  : desc_adr_q;
  assign size_lat = accept ? desc_size_i : desc_size_q;

  function automatic logic is_write(input state_t s);
    return (s == WR_ADR) || (s == WR_SIZE) || (s == WR_BURST) ||
           (s == WR_EN)  || (s == CLR_IRQ);
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; bus_gap forces one idle bus cycle after ack or rty.
  always_comb begin
    state_d = state_q;
    bus_gap = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = (desc_size_i == '0) ? DONE : WR_ADR;
      end
      WR_ADR, WR_SIZE, WR_BURST, WR_EN, CLR_IRQ: begin
        if (wbm_stb_o) begin
          if (wbm_err_i) begin
            state_d = ERROR;
          end else if (wbm_rty_i) begin
            bus_gap = 1'b1;
          end else if (wbm_ack_i) begin
            bus_gap = 1'b1;
            case (state_q)
              WR_ADR:   state_d = WR_SIZE;
              WR_SIZE:  state_d = WR_BURST;
              WR_BURST: state_d = WR_EN;
              WR_EN:    state_d = WAIT_IRQ;
              default:  state_d = DONE;
            endcase
          end
        end
      end
      WAIT_IRQ: begin
        if (writer_irq_i) state_d = CLR_IRQ;
      end
      DONE: begin
        state_d = IDLE;
      end
      ERROR: begin
        if (err_clr_i) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode: address/data of the write to present next cycle.
  always_comb begin
    stb_d = is_write(state_d) && !bus_gap;
    adr_d = '0;
    dat_d = '0;
    if (stb_d) begin
      case (state_d)
        WR_ADR:   begin adr_d = REG_ADR;   dat_d = WB_DW'(adr_lat);   end
        WR_SIZE:  begin adr_d = REG_SIZE;  dat_d = WB_DW'(size_lat);  end
        WR_BURST: begin adr_d = REG_BURST; dat_d = WB_DW'(BURST_LEN); end
        WR_EN:    begin adr_d = REG_CTRL;  dat_d = WB_DW'(1);         end
        default:  begin adr_d = REG_CTRL;  dat_d = WB_DW'(2);         end
      endcase
    end
  end

  // Descriptor latch, refreshed on every accepted handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      desc_adr_q  <= '0;
      desc_size_q <= '0;
    end else if (accept) begin
      desc_adr_q  <= desc_adr_i;
      desc_size_q <= desc_size_i;
    end
  end

  // Registered Wishbone master outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      wbm_sel_o <= '0;
    end else begin
      wbm_cyc_o <= stb_d;
      wbm_stb_o <= stb_d;
      wbm_we_o  <= stb_d;
      wbm_adr_o <= adr_d;
      wbm_dat_o <= dat_d;
      wbm_sel_o <= {(WB_DW/8){stb_d}};
    end
  end

  // Registered status: busy, sticky error, done pulse and completion count.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      done_cnt_q <= '0;
    end else begin
      busy_o <= (state_d != IDLE) && (state_d != ERROR);
      err_o  <= (state_d == ERROR);
      done_o <= (state_q == DONE);
      if (state_q == DONE) done_cnt_q <= done_cnt_q + 16'd1;
    end
  end

endmodule
